csr_dma_addr_gen: RTL and testbench

- Multi-channel DMA read/write address generator, configured through the CSR block's channel registers: baddr, len, loop, stride, chnl, run, irq_clr, ready, done, error.
- Generalises the fixed single-read/single-write CSR channel pair to NUM_CH channels.
- Converts each channel's 2-D transfer descriptor (loop lines of len beats, stride bytes apart) into a round-robin-arbitrated stream of burst requests to the bus master.
- Returns per-channel ready/done/error status and a combined interrupt.

---
 rtl/csr_dma_addr_gen.sv | 269 ++++++++++++++++++++++++++
 tb/tb_csr_dma_addr_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_dma_addr_gen.sv
// csr_dma_addr_gen: multi-channel 2-D DMA address generator.
// Each channel walks a descriptor of `loop` lines of `len` beats, lines
// `stride` bytes apart, and offers bursts to a registered round-robin
// arbiter that drives a single request port.
// Optional build macro: CSR_DMA_4K_SPLIT_EN (when defined, no burst crosses
// a 4 KiB address boundary).
module csr_dma_addr_gen #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned LW        = 16,
  parameter int unsigned BPB       = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [AW-1:0]             cfg_baddr,
  input  logic [LW-1:0]             cfg_len,
  input  logic [LW-1:0]             cfg_loop,
  input  logic [AW-1:0]             cfg_stride,
  input  logic                      cfg_run,
  input  logic [NUM_CH-1:0]         irq_clr,
  output logic [NUM_CH-1:0]         ready,
  output logic [NUM_CH-1:0]         done,
  output logic [3*NUM_CH-1:0]       error,
  output logic                      irq,
  output logic                      req_vld,
  input  logic                      req_rdy,
  output logic [AW-1:0]             req_addr,
  output logic [7:0]                req_beats,
  output logic [$clog2(NUM_CH)-1:0] req_ch
);

  localparam int unsigned   CW         = $clog2(NUM_CH);
  localparam int unsigned   BSH        = $clog2(BPB);
  localparam logic [AW-1:0] ALIGN_MASK = AW'(BPB - 1);

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_ACTIVE = 2'd1,
    CH_DONE   = 2'd2
  } ch_state_e;

  // Per-channel descriptor and progress state
  ch_state_e     st_q        [NUM_CH];
  ch_state_e     st_d        [NUM_CH];
  logic [AW-1:0] line_addr_q [NUM_CH];
  logic [AW-1:0] line_addr_d [NUM_CH];
  logic [AW-1:0] cur_addr_q  [NUM_CH];
  logic [AW-1:0] cur_addr_d  [NUM_CH];
  logic [AW-1:0] stride_q    [NUM_CH];
  logic [AW-1:0] stride_d    [NUM_CH];
  logic [LW-1:0] len_q       [NUM_CH];
  logic [LW-1:0] len_d       [NUM_CH];
  logic [LW-1:0] rem_q       [NUM_CH];
  logic [LW-1:0] rem_d       [NUM_CH];
  logic [LW-1:0] lines_q     [NUM_CH];
  logic [LW-1:0] lines_d     [NUM_CH];
  logic [2:0]    err_q       [NUM_CH];
  logic [2:0]    err_d       [NUM_CH];

  // Arbiter / request port state
  logic          req_vld_q, req_vld_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [7:0]    req_beats_q, req_beats_d;
  logic [CW-1:0] req_ch_q, req_ch_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic          irq_q, irq_d;

  // Acceptance of the presented burst
  logic          acc;
  logic [8:0]    acc_beats;
  logic [AW-1:0] acc_bytes;
  logic [2:0]    run_err;

  // Arbiter working signals
  logic          found;
  logic [CW-1:0] gnt;
  logic [CW-1:0] cidx;
  int unsigned   idx;
  logic [AW-1:0] sel_addr;
  logic [LW-1:0] sel_rem;
  logic [8:0]    blen;
`ifdef CSR_DMA_4K_SPLIT_EN
  logic [12:0]   room;
`endif

  // Channel update scratch
  logic [LW-1:0] rem_nx;
  logic [AW-1:0] line_nx;

  assign acc       = req_vld_q & req_rdy;
  assign acc_beats = {1'b0, req_beats_q} + 9'd1;
  assign acc_bytes = AW'(acc_beats) << BSH;
  assign run_err   = {|(cfg_baddr & ALIGN_MASK), cfg_loop == '0, cfg_len == '0};

  // Per-channel next state: launch, burst bookkeeping, completion and clear
  always_comb begin
    rem_nx  = '0;
    line_nx = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      st_d[c]        = st_q[c];
      line_addr_d[c] = line_addr_q[c];
      cur_addr_d[c]  = cur_addr_q[c];
      stride_d[c]    = stride_q[c];
      len_d[c]       = len_q[c];
      rem_d[c]       = rem_q[c];
      lines_d[c]     = lines_q[c];
      err_d[c]       = err_q[c];
      case (st_q[c])
        CH_IDLE: begin
          if (cfg_run && (cfg_ch == CW'(c))) begin
            line_addr_d[c] = cfg_baddr;
            cur_addr_d[c]  = cfg_baddr;
            stride_d[c]    = cfg_stride;
            len_d[c]       = cfg_len;
            rem_d[c]       = cfg_len;
            lines_d[c]     = cfg_loop;
            err_d[c]       = run_err;
            st_d[c]        = (|run_err) ? CH_DONE : CH_ACTIVE;
          end
        end
        CH_ACTIVE: begin
          // State only advances when this channel's presented burst is taken
          if (acc && (req_ch_q == CW'(c))) begin
            rem_nx  = rem_q[c] - LW'(acc_beats);
            line_nx = line_addr_q[c] + stride_q[c];
            if (rem_nx != '0) begin
              rem_d[c]      = rem_nx;
              cur_addr_d[c] = cur_addr_q[c] + acc_bytes;
            end else if (lines_q[c] > LW'(1)) begin
              line_addr_d[c] = line_nx;
              cur_addr_d[c]  = line_nx;
              rem_d[c]       = len_q[c];
              lines_d[c]     = lines_q[c] - LW'(1);
            end else begin
              rem_d[c] = '0;
              st_d[c]  = CH_DONE;
            end
          end
        end
        CH_DONE: begin
          // Clear wins over a same-cycle run: run is only honoured in IDLE
          if (irq_clr[c]) begin
            err_d[c] = '0;
            st_d[c]  = CH_IDLE;
          end
        end
        default: st_d[c] = CH_IDLE;
      endcase
    end
  end

  // Round-robin pick and burst sizing for the next presented request
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cidx  = '0;
    idx   = 0;
    // The channel being accepted this cycle still shows pre-burst state, so
    // it is skipped; it becomes eligible again one cycle later.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cidx = CW'(idx);
      if (!found && (st_q[cidx] == CH_ACTIVE) && !(acc && (req_ch_q == cidx))) begin
        found = 1'b1;
        gnt   = cidx;
      end
    end

    sel_addr = cur_addr_q[gnt];
    sel_rem  = rem_q[gnt];
    if (32'(sel_rem) > MAX_BURST) blen = 9'(MAX_BURST);
    else                          blen = 9'(sel_rem);
`ifdef CSR_DMA_4K_SPLIT_EN
    room = (13'd4096 - {1'b0, sel_addr[11:0]}) >> BSH;
    if ({4'b0, blen} > room) blen = room[8:0];
`endif

    req_vld_d   = req_vld_q;
    req_addr_d  = req_addr_q;
    req_beats_d = req_beats_q;
    req_ch_d    = req_ch_q;
    ptr_d       = ptr_q;
    if (!req_vld_q || req_rdy) begin
      req_vld_d = found;
      if (found) begin
        req_addr_d  = sel_addr;
        req_beats_d = 8'(blen - 9'd1);
        req_ch_d    = gnt;
        ptr_d       = (32'(gnt) == NUM_CH - 1) ? '0 : gnt + CW'(1);
      end
    end
  end

  // Interrupt tracks the next-cycle done vector so it aligns with done
  always_comb begin
    irq_d = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (st_d[c] == CH_DONE) irq_d = 1'b1;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        st_q[c]        <= CH_IDLE;
        line_addr_q[c] <= '0;
        cur_addr_q[c]  <= '0;
        stride_q[c]    <= '0;
        len_q[c]       <= '0;
        rem_q[c]       <= '0;
        lines_q[c]     <= '0;
        err_q[c]       <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        st_q[c]        <= st_d[c];
        line_addr_q[c] <= line_addr_d[c];
        cur_addr_q[c]  <= cur_addr_d[c];
        stride_q[c]    <= stride_d[c];
        len_q[c]       <= len_d[c];
        rem_q[c]       <= rem_d[c];
        lines_q[c]     <= lines_d[c];
        err_q[c]       <= err_d[c];
      end
    end
  end

  // Request port, arbiter pointer and interrupt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld_q   <= 1'b0;
      req_addr_q  <= '0;
      req_beats_q <= '0;
      req_ch_q    <= '0;
      ptr_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      req_vld_q   <= req_vld_d;
      req_addr_q  <= req_addr_d;
      req_beats_q <= req_beats_d;
      req_ch_q    <= req_ch_d;
      ptr_q       <= ptr_d;
      irq_q       <= irq_d;
    end
  end

  // Status outputs decoded from channel state
  always_comb begin
    ready = '0;
    done  = '0;
    error = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ready[c]         = (st_q[c] == CH_IDLE);
      done[c]          = (st_q[c] == CH_DONE);
      error[3*c +: 3]  = err_q[c];
    end
  end

  assign irq       = irq_q;
  assign req_vld   = req_vld_q;
  assign req_addr  = req_addr_q;
  assign req_beats = req_beats_q;
  assign req_ch    = req_ch_q;

endmodule

// File: tb/tb_csr_dma_addr_gen.sv
// Testbench for csr_dma_addr_gen: directed scenarios plus a randomized phase,
// all checked against a transaction-level model of the channels (expected
// burst lists computed from each descriptor, and per-channel idle/busy/done).
module tb_csr_dma_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_baddr = '0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_loop = '0;
  logic [31:0] cfg_stride = '0;
  logic        cfg_run = 1'b0;
  logic [3:0]  irq_clr = '0;
  logic [3:0]  ready;
  logic [3:0]  done;
  logic [11:0] error;
  logic        irq;
  logic        req_vld;
  logic        req_rdy = 1'b0;
  logic [31:0] req_addr;
  logic [7:0]  req_beats;
  logic [1:0]  req_ch;

  csr_dma_addr_gen #(
    .NUM_CH(4), .AW(32), .LW(16), .BPB(4), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_ch(cfg_ch), .cfg_baddr(cfg_baddr),
    .cfg_len(cfg_len), .cfg_loop(cfg_loop), .cfg_stride(cfg_stride),
    .cfg_run(cfg_run), .irq_clr(irq_clr), .ready(ready), .done(done),
    .error(error), .irq(irq), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_addr(req_addr), .req_beats(req_beats), .req_ch(req_ch)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [7:0]  beats;
  } burst_t;

  burst_t      expq[$];
  int          acc_log[$];
  int          mst[4];   // 0 idle, 1 busy, 2 done
  logic [2:0]  merr[4];
  logic        prev_vld, prev_rdy;
  logic [31:0] prev_addr;
  logic [7:0]  prev_beats;
  logic [1:0]  prev_ch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bursts: walk lines and beats with plain arithmetic
  task automatic push_bursts(input int ch, input logic [31:0] baddr, input int len,
                             input int loop, input logic [31:0] stride);
    logic [31:0] la, a;
    int r, b;
    burst_t e;
    la = baddr;
    for (int l = 0; l < loop; l++) begin
      a = la;
      r = len;
      while (r > 0) begin
        b = (r > 16) ? 16 : r;
`ifdef CSR_DMA_4K_SPLIT_EN
        if ((4096 - int'(a % 4096)) / 4 < b) b = (4096 - int'(a % 4096)) / 4;
`endif
        e.ch = ch; e.addr = a; e.beats = 8'(b - 1);
        expq.push_back(e);
        a = a + 32'(b * 4);
        r = r - b;
      end
      la = la + stride;
    end
  endtask

  function automatic bit busy_any();
    busy_any = 1'b0;
    for (int c = 0; c < 4; c++) if (mst[c] == 1) busy_any = 1'b1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin mst[c] = 0; merr[c] = '0; end
    expq.delete();
    prev_vld = 1'b0; prev_rdy = 1'b0;
    prev_addr = '0; prev_beats = '0; prev_ch = '0;
  endtask

  // Compare this cycle's outputs to the model, then advance the model
  task automatic monitor();
    logic [3:0]  er, ed;
    logic [11:0] ee;
    int          nst[4];
    int          fidx, left, ch;
    logic [2:0]  le;
    er = '0; ed = '0; ee = '0;
    for (int c = 0; c < 4; c++) begin
      er[c] = (mst[c] == 0);
      ed[c] = (mst[c] == 2);
      ee[3*c +: 3] = merr[c];
    end
    chk("ready", ready, er);
    chk("done", done, ed);
    chk("irq", irq, |ed);
    chk("error", error, ee);
    if (prev_vld && !prev_rdy) begin
      chk("hold_vld", req_vld, 1'b1);
      chk("hold_addr", req_addr, prev_addr);
      chk("hold_beats", req_beats, prev_beats);
      chk("hold_ch", req_ch, prev_ch);
    end
    for (int c = 0; c < 4; c++) nst[c] = mst[c];
    if (req_vld === 1'b1) begin
      ch = int'(req_ch);
      fidx = -1;
      for (int i = 0; i < expq.size(); i++) if (fidx < 0 && expq[i].ch == ch) fidx = i;
      chk("req_has_burst", (fidx >= 0), 1'b1);
      if (fidx >= 0) begin
        chk("req_addr", req_addr, expq[fidx].addr);
        chk("req_beats", req_beats, expq[fidx].beats);
        if (req_rdy) begin
          acc_log.push_back(ch);
          expq.delete(fidx);
          left = 0;
          for (int i = 0; i < expq.size(); i++) if (expq[i].ch == ch) left++;
          if (left == 0) nst[ch] = 2;
        end
      end
    end
    if (cfg_run && mst[int'(cfg_ch)] == 0) begin
      le = {cfg_baddr[1:0] != 2'b00, cfg_loop == 16'd0, cfg_len == 16'd0};
      merr[int'(cfg_ch)] = le;
      if (le != 3'b000) nst[int'(cfg_ch)] = 2;
      else begin
        nst[int'(cfg_ch)] = 1;
        push_bursts(int'(cfg_ch), cfg_baddr, int'(cfg_len), int'(cfg_loop), cfg_stride);
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (irq_clr[c] && mst[c] == 2) begin nst[c] = 0; merr[c] = '0; end
    end
    prev_vld = req_vld; prev_rdy = req_rdy;
    prev_addr = req_addr; prev_beats = req_beats; prev_ch = req_ch;
    for (int c = 0; c < 4; c++) mst[c] = nst[c];
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int ch, input logic [31:0] a, input logic [15:0] l,
                        input logic [15:0] lp, input logic [31:0] s);
    cfg_ch = 2'(ch); cfg_baddr = a; cfg_len = l; cfg_loop = lp; cfg_stride = s;
    cfg_run = 1'b1;
    step();
    cfg_run = 1'b0;
  endtask

  task automatic clear(input logic [3:0] m);
    irq_clr = m;
    step();
    irq_clr = '0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy_any()) && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", (expq.size() == 0 && !busy_any()), 1'b1);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 4'hF);
    chk("rst_done", done, 4'h0);
    chk("rst_error", error, 12'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_vld", req_vld, 1'b0);
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_beats", req_beats, 8'h0);
    chk("rst_ch", req_ch, 2'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic single-line transfer and run-to-request latency
    req_rdy = 1'b1;
    launch(0, 32'h1000, 16'd40, 16'd1, 32'h0);
    chk("lat_n1_vld", req_vld, 1'b0);
    step();
    chk("lat_n2_vld", req_vld, 1'b1);
    chk("lat_n2_addr", req_addr, 32'h1000);
    chk("lat_n2_beats", req_beats, 8'd15);
    drain(100);
    chk("basic_done", done[0], 1'b1);
    chk("basic_irq", irq, 1'b1);
    clear(4'b0001);
    chk("basic_clr_ready", ready[0], 1'b1);

    // Two lines with stride, then clear
    launch(1, 32'h2000, 16'd4, 16'd2, 32'h100);
    drain(100);
    chk("two_done", done[1], 1'b1);
    clear(4'b0010);
    chk("two_clr_ready", ready[1], 1'b1);
    chk("two_clr_done", done[1], 1'b0);

    // Round-robin order with a 5-cycle stall
    acc_log.delete();
    req_rdy = 1'b0;
    for (int c = 0; c < 4; c++) launch(c, 32'h3000 + 32'(c) * 32'h1000, 16'd32, 16'd1, 32'h0);
    step();
    req_rdy = 1'b1;
    n = 0;
    while (acc_log.size() < 3 && n < 50) begin step(); n++; end
    chk("rr_wait3", (acc_log.size() >= 3), 1'b1);
    req_rdy = 1'b0;
    repeat (5) step();
    req_rdy = 1'b1;
    drain(200);
    chk("rr_count", acc_log.size(), 8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++) chk("rr_order", acc_log[i], i % 4);
    clear(4'hF);

    // Descriptor errors
    launch(2, 32'h1000, 16'd0, 16'd1, 32'h0);
    step();
    chk("err_len0", error[8:6], 3'b001);
    chk("err_len0_done", done[2], 1'b1);
    launch(3, 32'h1002, 16'd4, 16'd1, 32'h0);
    step();
    chk("err_align", error[11:9], 3'b100);
    clear(4'b1100);

    // Run to an active channel is ignored
    req_rdy = 1'b0;
    launch(0, 32'h7000, 16'd40, 16'd1, 32'h0);
    step();
    launch(0, 32'h7800, 16'd8, 16'd2, 32'h40);
    req_rdy = 1'b1;
    drain(100);
    chk("ign_done", done[0], 1'b1);

    // Clear and run together on a DONE channel: clear wins
    cfg_ch = 2'd0; cfg_baddr = 32'h5000; cfg_len = 16'd4; cfg_loop = 16'd1;
    cfg_run = 1'b1; irq_clr = 4'b0001;
    step();
    cfg_run = 1'b0; irq_clr = '0;
    repeat (3) step();
    chk("clr_run_ready", ready[0], 1'b1);
    chk("clr_run_novld", req_vld, 1'b0);

    // Address wrap (and 4 KiB split when enabled)
    launch(1, 32'hFFFF_FFF0, 16'd8, 16'd1, 32'h0);
    step();
    chk("wrap_addr", req_addr, 32'hFFFF_FFF0);
`ifdef CSR_DMA_4K_SPLIT_EN
    chk("wrap_beats", req_beats, 8'd3);
`else
    chk("wrap_beats", req_beats, 8'd7);
`endif
    drain(100);
    clear(4'b0010);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      req_rdy   = ($urandom % 4) != 0;
      cfg_ch    = 2'($urandom % 4);
      cfg_run   = ($urandom % 4) == 0;
      cfg_baddr = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 16) == 0) cfg_baddr[1:0] = 2'($urandom_range(1, 3));
      cfg_len    = 16'($urandom_range(0, 40));
      cfg_loop   = 16'($urandom_range(0, 3));
      cfg_stride = $urandom & 32'h0000_3FFC;
      irq_clr    = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
      step();
    end
    cfg_run = 1'b0; irq_clr = '0; req_rdy = 1'b1;
    drain(2000);
    clear(4'hF);

    // Asynchronous reset while a request is pending
    req_rdy = 1'b0;
    launch(2, 32'h8000, 16'd16, 16'd1, 32'h0);
    step();
    chk("pre_rst_vld", req_vld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", req_vld, 1'b0);
    chk("arst_ready", ready, 4'hF);
    chk("arst_done", done, 4'h0);
    chk("arst_irq", irq, 1'b0);
    chk("arst_error", error, 12'h0);
    chk("arst_addr", req_addr, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_rdy = 1'b1;
    launch(2, 32'h9000, 16'd20, 16'd1, 32'h0);
    drain(100);
    chk("post_rst_done", done[2], 1'b1);
    chk("post_rst_err", error[8:6], 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
